match_referee: RTL

- Penalty-shootout scorekeeper; the producer side of the match_end / match_result interface consumed by the next-state controller.
- Takes shot-outcome pulses from the gameplay logic, counts goals per side and enforces alternating shooters.
- Detects an early decision, regulation end and sudden death, then raises match_end with match_result.
- Clears itself whenever game_state returns to START.

---
 rtl/match_referee.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/match_referee.sv
// Penalty-shootout referee: counts goals per side, enforces alternating shooters
// and raises match_end/match_result once the shootout is decided.
// Optional feature macro: MATCH_SUDDEN_DEATH_EN (builds the sudden-death phase;
// without it a tie after regulation ends the match as a loss).

package game_pkg;
  typedef enum logic [2:0] {START, KEEPER, SHOOTER, WINNER, LOSER} g_state;
endpackage

module match_referee
  import game_pkg::*;
#(
  parameter int REG_SHOTS    = 5,
  parameter int MAX_SUDDEN   = 10,
  parameter int PLAYER_FIRST = 0,
  parameter int CW           = $clog2(REG_SHOTS + MAX_SUDDEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  g_state        game_state,
  input  logic          shot_done,
  input  logic          shot_by_player,
  input  logic          shot_goal,
  output logic          match_end,
  output logic          match_result,
  output logic [CW-1:0] player_goals,
  output logic [CW-1:0] opp_goals,
  output logic [CW-1:0] round_cnt,
  output logic          next_is_player,
  output logic          seq_err
);

  localparam logic PF = PLAYER_FIRST[0];
  localparam logic [CW:0] REG_W = (CW+1)'(REG_SHOTS);
`ifdef MATCH_SUDDEN_DEATH_EN
  localparam logic [CW:0] LAST_RND = (CW+1)'(REG_SHOTS + MAX_SUDDEN);
`endif

`ifdef MATCH_SUDDEN_DEATH_EN
  typedef enum logic [1:0] {IDLE, REGULAR, SUDDEN, DONE} st_t;
`else
  typedef enum logic [1:0] {IDLE, REGULAR, DONE} st_t;
`endif

  st_t state, state_nxt;

  logic in_play, acc, ooo, second, half_n, end_set, end_res;
  logic [CW:0] pg_n, og_n, rc_n, first_n, p_shots, o_shots, p_rem, o_rem;

`ifdef MATCH_SUDDEN_DEATH_EN
  assign in_play = (state == REGULAR) || (state == SUDDEN);
`else
  assign in_play = (state == REGULAR);
`endif
  assign acc    = in_play && shot_done && (shot_by_player == next_is_player);
  assign ooo    = in_play && shot_done && (shot_by_player != next_is_player);
  assign second = (shot_by_player != PF);

  // Post-shot counts and remaining regulation shots per side
  always_comb begin
    pg_n    = {1'b0, player_goals} + {{CW{1'b0}}, acc && shot_by_player && shot_goal};
    og_n    = {1'b0, opp_goals} + {{CW{1'b0}}, acc && !shot_by_player && shot_goal};
    rc_n    = {1'b0, round_cnt} + {{CW{1'b0}}, acc && second};
    // half_n: first shooter of the current round has already shot
    half_n  = acc ? !second : (next_is_player != PF);
    first_n = rc_n + {{CW{1'b0}}, half_n};
    p_shots = PF ? first_n : rc_n;
    o_shots = PF ? rc_n : first_n;
    p_rem   = REG_W - p_shots;
    o_rem   = REG_W - o_shots;
  end

  // Phase state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next phase and decision detection on accepted shots
  always_comb begin
    state_nxt = state;
    end_set   = 1'b0;
    end_res   = 1'b0;
    if (game_state == START) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (game_state == KEEPER || game_state == SHOOTER) state_nxt = REGULAR;
        REGULAR: if (acc) begin
          if (pg_n > og_n + o_rem) begin
            state_nxt = DONE; end_set = 1'b1; end_res = 1'b1;
          end else if (og_n > pg_n + p_rem) begin
            state_nxt = DONE; end_set = 1'b1;
          end else if (rc_n == REG_W && pg_n == og_n) begin
`ifdef MATCH_SUDDEN_DEATH_EN
            state_nxt = SUDDEN;
`else
            state_nxt = DONE; end_set = 1'b1;
`endif
          end
        end
`ifdef MATCH_SUDDEN_DEATH_EN
        // Sudden death only decides at the end of a full round
        SUDDEN: if (acc && second) begin
          if (pg_n != og_n) begin
            state_nxt = DONE; end_set = 1'b1; end_res = (pg_n > og_n);
          end else if (rc_n == LAST_RND) begin
            state_nxt = DONE; end_set = 1'b1;
          end
        end
`endif
        default: state_nxt = state;
      endcase
    end
  end

  // Score, turn, error and result registers
  always_ff @(posedge clk) begin
    if (rst || game_state == START) begin
      player_goals   <= '0;
      opp_goals      <= '0;
      round_cnt      <= '0;
      next_is_player <= PF;
      seq_err        <= 1'b0;
      match_end      <= 1'b0;
      match_result   <= 1'b0;
    end else begin
      if (acc) begin
        player_goals   <= pg_n[CW-1:0];
        opp_goals      <= og_n[CW-1:0];
        round_cnt      <= rc_n[CW-1:0];
        next_is_player <= !next_is_player;
      end
      if (ooo) seq_err <= 1'b1;
      if (end_set) begin
        match_end    <= 1'b1;
        match_result <= end_res;
      end
    end
  end

endmodule
